// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle for seq_alu: the controller drives the
// master side, seq_alu implements the slave side.
interface seq_alu_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [2:0]       opc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] w;
  logic             zero;
  logic             neg;
  logic             carry;

  modport master (
    output in_valid, a, b, cin, opc, out_ready,
    input  in_ready, out_valid, w, zero, neg, carry
  );

  modport slave (
    input  in_valid, a, b, cin, opc, out_ready,
    output in_ready, out_valid, w, zero, neg, carry
  );
endinterface

// File: rtl/seq_alu.sv
// Registered WIDTH-bit ALU with valid/ready on both sides. Define ALU_MUL_EN to
// make opcode 7 a multi-cycle shift-add multiply; otherwise opcode 7 is SHR.
module seq_alu #(
  parameter int WIDTH = 16
) (
  input logic        clk,
  input logic        rst_n,
  seq_alu_if.slave   bus
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_7   = 3'd7;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;

  logic             in_ready;
  logic             accept;
  logic             pop;
  logic [WIDTH-1:0] alu_w;
  logic             alu_c;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] acc_sum;

  assign in_ready = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
`else
  assign in_ready = !out_valid_q || bus.out_ready;
`endif

  assign accept = bus.in_valid && in_ready;
  assign pop    = out_valid_q && bus.out_ready;

  // Single-cycle datapath; the borrow of SUB is the sign bit of the widened difference.
  always_comb begin
    alu_w = '0;
    alu_c = 1'b0;
    sum   = {1'b0, bus.a} + {1'b0, bus.b} + (WIDTH+1)'(bus.cin);
    diff  = {1'b0, bus.a} - {1'b0, bus.b} - (WIDTH+1)'(bus.cin);
    case (bus.opc)
      OP_ADD: begin
        alu_w = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
      end
      OP_SUB: begin
        alu_w = diff[WIDTH-1:0];
        alu_c = diff[WIDTH];
      end
      OP_AND: alu_w = bus.a & bus.b;
      OP_OR:  alu_w = bus.a | bus.b;
      OP_XOR: alu_w = bus.a ^ bus.b;
      OP_NOT: alu_w = ~bus.a;
      OP_SHL: begin
        alu_w = {bus.a[WIDTH-2:0], bus.cin};
        alu_c = bus.a[WIDTH-1];
      end
      OP_7: begin
`ifdef ALU_MUL_EN
        alu_w = '0;
        alu_c = 1'b0;
`else
        alu_w = {bus.cin, bus.a[WIDTH-1:1]};
        alu_c = bus.a[0];
`endif
      end
      default: begin
        alu_w = '0;
        alu_c = 1'b0;
      end
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    w_d         = w_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    carry_d     = carry_q;
`ifdef ALU_MUL_EN
    state_d     = state_q;
    count_d     = count_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    acc_sum     = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

    if (pop) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
`ifdef ALU_MUL_EN
      if (bus.opc == OP_7) begin
        out_valid_d = 1'b0;
        mcand_d     = {{WIDTH{1'b0}}, bus.a};
        mplier_d    = bus.b;
        acc_d       = '0;
        count_d     = '0;
        state_d     = BUSY;
      end else begin
`else
      begin
`endif
        out_valid_d = 1'b1;
        w_d         = alu_w;
        zero_d      = (alu_w == '0);
        neg_d       = alu_w[WIDTH-1];
        carry_d     = alu_c;
      end
    end

`ifdef ALU_MUL_EN
    // One multiplier bit per edge, LSB first; the last bit publishes the product.
    if (state_q == BUSY) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q + CW'(1);
      if (count_q == CW'(WIDTH-1)) begin
        w_d         = acc_sum[WIDTH-1:0];
        zero_d      = (acc_sum[WIDTH-1:0] == '0);
        neg_d       = acc_sum[WIDTH-1];
        carry_d     = |acc_sum[2*WIDTH-1:WIDTH];
        out_valid_d = 1'b1;
        count_d     = '0;
        state_d     = IDLE;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      w_q         <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      carry_q     <= 1'b0;
`ifdef ALU_MUL_EN
      state_q     <= IDLE;
      count_q     <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      w_q         <= w_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      carry_q     <= carry_d;
`ifdef ALU_MUL_EN
      state_q     <= state_d;
      count_q     <= count_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.w         = w_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
  assign bus.carry     = carry_q;

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered ALU with a valid/ready handshake on both sides and flags for zero, negative and carry. It extends the team's 16-bit eight-opcode combinational ALU to any width and registers the result. It adds a multi-cycle shift-add multiply and sits between an operand-issuing controller and a result consumer. Throughput is one op per cycle for single-cycle ops; a multiply holds the block busy.

## Interface
- WIDTH, default 16: operand/result width; legal range ≥ 2.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set offered.
- in_ready  output  1  block will accept at this edge.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry/borrow/shift-in bit.
- opc  input  3  opcode.
- out_valid  output  1  result registers hold a valid result.
- out_ready  input  1  consumer takes the result at this edge.
- w  output  WIDTH  result.
- zero  output  1  w == 0.
- neg  output  1  w[WIDTH-1].
- carry  output  1  carry, borrow or shifted-out bit.

## Operation
- Accept: in_valid && in_ready at an edge.
- Pop: out_valid && out_ready at an edge.
- in_ready = (state == IDLE) && (!out_valid || out_ready). It is combinational and never depends on in_valid.
- Opcodes:
  - 0 ADD: {carry, w} = a + b + cin.
  - 1 SUB: w = a − b − cin, mod 2^WIDTH. carry = 1 on borrow, i.e. a < b + cin.
  - 2 AND, 3 OR, 4 XOR, 5 NOT a: carry = 0.
  - 6 SHL: w = {a[WIDTH-2:0], cin}, carry = a[WIDTH-1].
  - 7: MUL or SHR, selected by the Configuration macro.
- Flags zero and neg are always derived from the registered w. They are captured in the same edge as w.
- States:
  - IDLE: single-cycle ops are computed combinationally and written to w/flags at the accept edge, with out_valid ← 1. An accepted MUL loads the multiplicand, multiplier and a 2·WIDTH accumulator (cleared), sets count = 0 and out_valid ← 0, then goes to BUSY.
  - BUSY: each edge processes one multiplier bit (LSB first): add the shifted multiplicand if the bit is set, then count += 1. At the edge where count reaches WIDTH−1 the final iteration completes: w ← low WIDTH bits, carry ← |high WIDTH bits, out_valid ← 1, next state IDLE.
- Pop without accept: out_valid ← 0; w and flags keep their values.
- Pop and accept in the same edge: the new result replaces the old one and out_valid stays 1. For a MUL, out_valid ← 0 until completion.
- With out_valid = 1 and out_ready = 0: w and flags hold stable and in_ready = 0.

## Timing
- Reset (asynchronous, immediate): out_valid = 0, w = 0, zero = 0, neg = 0, carry = 0, state = IDLE, count = 0. in_ready = 1 while reset is held and after release.
- Single-cycle op latency: result visible in the cycle following the accept edge. Sustained throughput is 1 op/cycle when out_ready = 1.
- MUL latency: accept at edge k, out_valid high after edge k+WIDTH (16 cycles at default width). in_ready = 0 for edges k+1..k+WIDTH.
- Reset mid-MUL aborts the op, leaves no result, and the block is ready on the first edge after release.
- Operand inputs are sampled only at the accept edge. Changes at other times have no effect.

## Configuration
- ALU_MUL_EN defined: opcode 7 = MUL (unsigned, truncated low WIDTH bits, carry = overflow into the high half). The BUSY state and the multiply datapath are present.
- ALU_MUL_EN undefined: opcode 7 = SHR, w = {cin, a[WIDTH-1:1]}, carry = a[0], single-cycle. No BUSY state, so in_ready depends only on the output register.

## Test plan
All values at WIDTH = 16.
- ADD: a = 0xFFFF, b = 0x0001, cin = 0 → w = 0x0000, zero = 1, carry = 1, neg = 0, out_valid the cycle after accept.
- SUB: a = 0x0003, b = 0x0005, cin = 0 → w = 0xFFFE, neg = 1, carry = 1, zero = 0.
- Opcode 7:
  - ALU_MUL_EN defined: a = 0x0100, b = 0x0100 → w = 0x0000, zero = 1, carry = 1, out_valid exactly 16 cycles after accept, in_ready = 0 throughout. Also a = 0x00FF, b = 0x0003 → w = 0x02FD, carry = 0.
  - ALU_MUL_EN undefined: a = 0x8001, cin = 1 → w = 0xC000, carry = 1, one-cycle latency.
- Backpressure: hold out_ready = 0 for 5 cycles with in_valid = 1 → in_ready = 0 and w/flags stable. Then raise out_ready → pop and accept in the same edge, out_valid stays 1, 10 back-to-back XORs complete in 10 cycles.
- Reset: assert rst_n = 0 at cycle 5 of a MUL → out_valid = 0, w = 0 immediately. After release, in_ready = 1 and AND 0xF0F0 & 0x0FF0 → 0x00F0.
- Random: 1000 accepted ops with random a, b, cin, opc and random out_ready → every popped result and flag set matches a golden model, in order, with none lost or duplicated.
